clock_time_counter: RTL and testbench

- Timekeeping core for the digital clock.
- Keeps 24-hour time (hour, minute, second) from a prescaled system clock.
- Supports a button-driven set mode for hour and minute.
- Drives hour24 directly into the downstream 12/24-hour display conversion stage; minute/second go to the display mux.

---
 rtl/clock_time_counter.sv | 138 +++++++++++++
 tb/tb_clock_time_counter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_counter.sv
// rtl/clock_time_counter.sv - 24-hour timekeeping core with button-driven hour/minute set mode
// Optional feature macro: CLOCK_ALARM_EN (adds alarm_hour/alarm_min/alarm_arm inputs and alarm_hit output)
module clock_time_counter #(
  parameter int CLK_HZ  = 50000000,
  parameter int PRESC_W = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_btn,
  input  logic       inc_btn,
`ifdef CLOCK_ALARM_EN
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic [0:0] alarm_arm,
  output logic       alarm_hit,
`endif
  output logic [4:0] hour24,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [1:0] mode,
  output logic       tick_1hz,
  output logic       day_rollover
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } mode_t;

  mode_t              state;
  mode_t              state_nxt;
  logic [PRESC_W-1:0] presc;

  logic       presc_term;
  logic       sec_wrap;
  logic       min_wrap;
  logic       hour_wrap;
  logic [5:0] sec_inc;
  logic [5:0] min_inc;
  logic [4:0] hour_inc;
  logic [5:0] run_sec;
  logic [5:0] run_min;
  logic [4:0] run_hour;
  logic       run_roll;

  assign mode = state;

  // Mode state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Mode next-state: mode_btn steps RUN -> SET_HOUR -> SET_MIN -> RUN
  always_comb begin
    state_nxt = state;
    if (mode_btn) begin
      case (state)
        RUN:      state_nxt = SET_HOUR;
        SET_HOUR: state_nxt = SET_MIN;
        SET_MIN:  state_nxt = RUN;
        default:  state_nxt = RUN;
      endcase
    end
  end

  // Per-field increments and the cascaded RUN-tick successor time
  always_comb begin
    presc_term = (presc == PRESC_W'(CLK_HZ - 1));
    sec_wrap   = (second == 6'd59);
    min_wrap   = (minute == 6'd59);
    hour_wrap  = (hour24 == 5'd23);
    sec_inc    = sec_wrap  ? 6'd0 : second + 6'd1;
    min_inc    = min_wrap  ? 6'd0 : minute + 6'd1;
    hour_inc   = hour_wrap ? 5'd0 : hour24 + 5'd1;
    run_sec    = sec_inc;
    run_min    = sec_wrap ? min_inc : minute;
    run_hour   = (sec_wrap && min_wrap) ? hour_inc : hour24;
    run_roll   = sec_wrap && min_wrap && hour_wrap;
  end

  // Prescaler, time fields and pulse outputs; a mode_btn edge takes priority over inc_btn
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc        <= '0;
      second       <= '0;
      minute       <= '0;
      hour24       <= '0;
      tick_1hz     <= 1'b0;
      day_rollover <= 1'b0;
`ifdef CLOCK_ALARM_EN
      alarm_hit    <= 1'b0;
`endif
    end else begin
      tick_1hz     <= 1'b0;
      day_rollover <= 1'b0;
`ifdef CLOCK_ALARM_EN
      alarm_hit    <= 1'b0;
`endif
      case (state)
        RUN: begin
          // Leaving RUN freezes the prescaler where it stands
          if (!mode_btn) begin
            if (presc_term) begin
              presc        <= '0;
              tick_1hz     <= 1'b1;
              second       <= run_sec;
              minute       <= run_min;
              hour24       <= run_hour;
              day_rollover <= run_roll;
`ifdef CLOCK_ALARM_EN
              alarm_hit    <= alarm_arm[0] && (run_sec == 6'd0) &&
                              (run_min == alarm_min) && (run_hour == alarm_hour);
`endif
            end else begin
              presc <= presc + PRESC_W'(1);
            end
          end
        end
        SET_HOUR: begin
          if (!mode_btn && inc_btn) hour24 <= hour_inc;
        end
        SET_MIN: begin
          // Returning to RUN starts a fresh, full second
          if (mode_btn) begin
            second <= '0;
            presc  <= '0;
          end else if (inc_btn) begin
            minute <= min_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_time_counter.sv
// tb/tb_clock_time_counter.sv - self-checking bench for clock_time_counter against a seconds-of-day model
module tb_clock_time_counter;

  localparam int HZ = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode_btn;
  logic       inc_btn;
  logic [4:0] hour24;
  logic [5:0] minute;
  logic [5:0] second;
  logic [1:0] mode;
  logic       tick_1hz;
  logic       day_rollover;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic [0:0] alarm_arm;
`ifdef CLOCK_ALARM_EN
  logic       alarm_hit;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: time as seconds since midnight, mode as 0/1/2, cycle count within the second
  int tod  = 0;
  int md   = 0;
  int pc   = 0;
  int tick_e, roll_e, hit_e;
  int n_tick, n_roll, n_hit, roll_at_tick, hit_at_tick;

  clock_time_counter #(.CLK_HZ(HZ), .PRESC_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode_btn     (mode_btn),
    .inc_btn      (inc_btn),
`ifdef CLOCK_ALARM_EN
    .alarm_hour   (alarm_hour),
    .alarm_min    (alarm_min),
    .alarm_arm    (alarm_arm),
    .alarm_hit    (alarm_hit),
`endif
    .hour24       (hour24),
    .minute       (minute),
    .second       (second),
    .mode         (mode),
    .tick_1hz     (tick_1hz),
    .day_rollover (day_rollover)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit m, input bit i, input bit r);
    int h, mi, s;
    tick_e = 0; roll_e = 0; hit_e = 0;
    h = tod / 3600; mi = (tod / 60) % 60; s = tod % 60;
    if (!r) begin
      tod = 0; md = 0; pc = 0;
    end else if (md == 0) begin
      if (m) md = 1;
      else if (pc == HZ - 1) begin
        pc = 0; tick_e = 1;
        tod = (tod + 1) % 86400;
        roll_e = (tod == 0);
        hit_e = (alarm_arm == 1'b1) && (tod % 60 == 0) &&
                (tod / 3600 == int'(alarm_hour)) && ((tod / 60) % 60 == int'(alarm_min));
      end else pc++;
    end else if (md == 1) begin
      if (m) md = 2;
      else if (i) tod = ((h + 1) % 24) * 3600 + mi * 60 + s;
    end else begin
      if (m) begin md = 0; pc = 0; tod = h * 3600 + mi * 60; end
      else if (i) tod = h * 3600 + ((mi + 1) % 60) * 60 + s;
    end
  endtask

  // One clock: drive inputs, step model at the edge, compare all outputs on the falling edge
  task automatic cyc(input bit m, input bit i, input bit r);
    rst_n = r; mode_btn = m; inc_btn = i;
    @(posedge clk);
    model_edge(m, i, r);
    @(negedge clk);
    chk("hour24", 32'(hour24), tod / 3600);
    chk("minute", 32'(minute), (tod / 60) % 60);
    chk("second", 32'(second), tod % 60);
    chk("mode", 32'(mode), md);
    chk("tick_1hz", 32'(tick_1hz), tick_e);
    chk("day_rollover", 32'(day_rollover), roll_e);
`ifdef CLOCK_ALARM_EN
    chk("alarm_hit", 32'(alarm_hit), hit_e);
    if (alarm_hit) begin n_hit++; hit_at_tick = n_tick + 1; end
`endif
    if (tick_1hz) n_tick++;
    if (day_rollover) begin n_roll++; roll_at_tick = n_tick; end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic incs(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
    alarm_hour = 5'd31; alarm_min = 6'd63; alarm_arm = 1'b0;
    @(negedge clk);

    // Reset and tick cadence
    do_reset();
    chk("reset_second", 32'(second), 0);
    chk("reset_mode", 32'(mode), 0);
    n_tick = 0;
    run(HZ);
    chk("first_tick_second", 32'(second), 1);
    run(2 * HZ);
    chk("third_tick_second", 32'(second), 3);
    chk("tick_count", n_tick, 3);

    // Set-mode wrap: hour +25, minute +61
    do_reset();
    n_tick = 0;
    cyc(1'b1, 1'b0, 1'b1);
    incs(25);
    chk("hour_wrap", 32'(hour24), 1);
    cyc(1'b1, 1'b0, 1'b1);
    incs(61);
    chk("minute_wrap", 32'(minute), 1);
    chk("no_tick_in_set", n_tick, 0);
    cyc(1'b1, 1'b0, 1'b1);

    // Full-day rollover from 23:59:00
    do_reset();
    cyc(1'b1, 1'b0, 1'b1);
    incs(23);
    cyc(1'b1, 1'b0, 1'b1);
    incs(59);
    cyc(1'b1, 1'b0, 1'b1);
    n_tick = 0; n_roll = 0; roll_at_tick = -1;
    run(60 * HZ);
    chk("roll_hour", 32'(hour24), 0);
    chk("roll_minute", 32'(minute), 0);
    chk("roll_count", n_roll, 1);
    chk("roll_at_tick", roll_at_tick, 60);

    // Exit set mode from second=37
    do_reset();
    run(37 * HZ);
    chk("pre_exit_second", 32'(second), 37);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("exit_second", 32'(second), 0);
    chk("exit_mode", 32'(mode), 0);
    n_tick = 0;
    run(HZ - 1);
    chk("no_early_tick", n_tick, 0);
    run(1);
    chk("tick_after_exit", 32'(tick_1hz), 1);

    // Simultaneous buttons in SET_HOUR
    do_reset();
    cyc(1'b1, 1'b0, 1'b1);
    incs(5);
    cyc(1'b1, 1'b1, 1'b1);
    chk("simul_mode", 32'(mode), 2);
    chk("simul_hour", 32'(hour24), 5);

    // Reset in the middle of a minute edit
    cyc(1'b0, 1'b0, 1'b1);
    incs(42);
    chk("pre_reset_minute", 32'(minute), 42);
    cyc(1'b0, 1'b0, 1'b0);
    chk("midset_mode", 32'(mode), 0);
    chk("midset_minute", 32'(minute), 0);
    chk("midset_hour", 32'(hour24), 0);

`ifdef CLOCK_ALARM_EN
    // Alarm at 00:01 armed fires on the 60th tick only
    alarm_hour = 5'd0; alarm_min = 6'd1; alarm_arm = 1'b1;
    do_reset();
    n_tick = 0; n_hit = 0; hit_at_tick = -1;
    run(61 * HZ);
    chk("alarm_count", n_hit, 1);
    chk("alarm_at_tick", hit_at_tick, 60);
    // Editing onto the alarm time in set mode does not fire
    n_hit = 0;
    do_reset();
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    incs(1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("alarm_no_edit_fire", n_hit, 0);
`endif

    // Randomized operation against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        alarm_hour = 5'($urandom_range(0, 31));
        alarm_min  = 6'($urandom_range(0, 63));
        alarm_arm  = 1'($urandom_range(0, 1));
      end
      cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 299) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
